// File: rtl/sram_bist_ctrl_pkg.sv
// Shared definitions for the March C- SRAM BIST controller: state and element
// encodings plus the constant March element table.
package sram_bist_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StE0,
        StE1,
        StE2,
        StE3,
        StE4,
        StE5,
        StDrain,
        StEnd
    } bist_state_e;

    typedef enum logic [2:0] {
        ElemE0   = 3'd0,
        ElemE1   = 3'd1,
        ElemE2   = 3'd2,
        ElemE3   = 3'd3,
        ElemE4   = 3'd4,
        ElemE5   = 3'd5,
        ElemIdle = 3'd7
    } bist_elem_e;

    // March C- table, one bit per element index (bits 6/7 unused padding).
    // Inv bits: 0 -> background pattern, 1 -> inverted pattern.
    localparam logic [7:0] ElemUp    = 8'b0000_0111; // E0..E2 ascend, E3..E5 descend
    localparam logic [7:0] ElemRd    = 8'b0011_1110; // element contains a read
    localparam logic [7:0] ElemWr    = 8'b0001_1111; // element contains a write
    localparam logic [7:0] ElemRdInv = 8'b0001_0100; // R1 in E2, E4
    localparam logic [7:0] ElemWrInv = 8'b0000_1010; // W1 in E1, E3

    // Element index reported for a state; the drain cycle still belongs to E5.
    function automatic bist_elem_e state_elem(bist_state_e st);
        unique case (st)
            StE0:    return ElemE0;
            StE1:    return ElemE1;
            StE2:    return ElemE2;
            StE3:    return ElemE3;
            StE4:    return ElemE4;
            StE5:    return ElemE5;
            StDrain: return ElemE5;
            default: return ElemIdle;
        endcase
    endfunction

    // State that follows an element once its last address is done.
    function automatic bist_state_e next_elem_state(bist_state_e st);
        unique case (st)
            StE0:    return StE1;
            StE1:    return StE2;
            StE2:    return StE3;
            StE3:    return StE4;
            StE4:    return StE5;
            StE5:    return StDrain;
            default: return StIdle;
        endcase
    endfunction

    function automatic logic is_elem_state(bist_state_e st);
        return (st == StE0) || (st == StE1) || (st == StE2) ||
               (st == StE3) || (st == StE4) || (st == StE5);
    endfunction

endpackage

// File: rtl/sram_bist_ctrl_port_mux.sv
// Owner-select mux for the single SRAM port: host when idle, BIST when busy.
module sram_port_mux #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
) (
    input  logic            bist_sel,
    input  logic            host_csb,
    input  logic            host_web,
    input  logic [DW/8-1:0] host_wmask,
    input  logic [AW-1:0]   host_addr,
    input  logic [DW-1:0]   host_din,
    input  logic            bist_csb,
    input  logic            bist_web,
    input  logic [AW-1:0]   bist_addr,
    input  logic [DW-1:0]   bist_din,
    output logic            sram_csb0,
    output logic            sram_web0,
    output logic [DW/8-1:0] sram_wmask0,
    output logic [AW-1:0]   sram_addr0,
    output logic [DW-1:0]   sram_din0
);

    // Pure select; BIST always writes full words.
    always_comb begin
        if (bist_sel) begin
            sram_csb0   = bist_csb;
            sram_web0   = bist_web;
            sram_wmask0 = '1;
            sram_addr0  = bist_addr;
            sram_din0   = bist_din;
        end else begin
            sram_csb0   = host_csb;
            sram_web0   = host_web;
            sram_wmask0 = host_wmask;
            sram_addr0  = host_addr;
            sram_din0   = host_din;
        end
    end

endmodule

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller and owner of the management SRAM 1rw port.
// Sequencer, address counter, read-compare pipeline and status live here.
module sram_bist_ctrl
    import sram_bist_ctrl_pkg::*;
#(
    parameter int unsigned   AW      = 9,
    parameter int unsigned   DW      = 32,
    parameter logic [DW-1:0] PATTERN = 32'h5555_5555
) (
    input  logic            core_clk,
    input  logic            core_rstn,
    input  logic            bist_start,
    output logic            bist_busy,
    output logic            bist_done,
    output logic            bist_fail,
    output logic [2:0]      bist_element,
    output logic [AW-1:0]   bist_fail_addr,
    output logic [DW-1:0]   bist_fail_exp,
    output logic [DW-1:0]   bist_fail_got,
    input  logic            host_csb,
    input  logic            host_web,
    input  logic [DW/8-1:0] host_wmask,
    input  logic [AW-1:0]   host_addr,
    input  logic [DW-1:0]   host_din,
    output logic [DW-1:0]   host_dout,
    output logic            host_gnt,
    output logic            sram_csb0,
    output logic            sram_web0,
    output logic [DW/8-1:0] sram_wmask0,
    output logic [AW-1:0]   sram_addr0,
    output logic [DW-1:0]   sram_din0,
    input  logic [DW-1:0]   sram_dout0
);

    localparam logic [AW-1:0] AddrMax = {AW{1'b1}};
    localparam logic [AW-1:0] AddrMin = '0;

    bist_state_e   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;     // RW elements: 0 = read, 1 = write
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [2:0]    element_q, element_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_exp_q, fail_exp_d;
    logic [DW-1:0] fail_got_q, fail_got_d;

    // Op presented to the macro this cycle (address is addr_q).
    logic          op_csb_q, op_csb_d;
    logic          op_web_q, op_web_d;
    logic [DW-1:0] op_din_q, op_din_d;
    logic          op_rd_q, op_rd_d;
    logic [DW-1:0] op_exp_q, op_exp_d;

    // Read issued last cycle whose data is on sram_dout0 now.
    logic          chk_vld_q, chk_vld_d;
    logic [AW-1:0] chk_addr_q, chk_addr_d;
    logic [DW-1:0] chk_exp_q, chk_exp_d;

    logic          mismatch;
    bist_elem_e    cur_elem;
    bist_elem_e    op_elem;
    bist_state_e   nxt_el_st;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] nxt_first;

    assign mismatch  = chk_vld_q && (sram_dout0 != chk_exp_q);
    assign cur_elem  = state_elem(state_q);
    assign last_addr = ElemUp[cur_elem] ? AddrMax : AddrMin;
    assign nxt_el_st = next_elem_state(state_q);
    assign nxt_first = ElemUp[state_elem(nxt_el_st)] ? AddrMin : AddrMax;

    // Sequencer: element stepping, address counter, start/abort/completion.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;

        unique case (state_q)
            StIdle, StEnd: begin
                state_d = StIdle;
                if (bist_start) begin
                    state_d = StE0;
                    addr_d  = AddrMin;
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            StE0, StE1, StE2, StE3, StE4, StE5: begin
                if (ElemRd[cur_elem] && ElemWr[cur_elem] && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == last_addr) begin
                        state_d = nxt_el_st;
                        addr_d  = nxt_first;
                    end else if (ElemUp[cur_elem]) begin
                        addr_d = addr_q + AW'(1);
                    end else begin
                        addr_d = addr_q - AW'(1);
                    end
                end
            end
            StDrain: begin
                state_d = StEnd;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // First mismatch aborts the run; nothing further is issued.
        if (mismatch) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            fail_d      = 1'b1;
            fail_addr_d = chk_addr_q;
            fail_exp_d  = chk_exp_q;
            fail_got_d  = sram_dout0;
        end
    end

    assign op_elem = state_elem(state_d);

    // Decode the op for the next cycle and stage the current read for compare.
    always_comb begin
        element_d = op_elem;
        op_csb_d  = 1'b1;
        op_web_d  = 1'b1;
        op_rd_d   = 1'b0;
        op_din_d  = PATTERN;
        op_exp_d  = PATTERN;
        if (is_elem_state(state_d)) begin
            op_csb_d = 1'b0;
            op_rd_d  = ElemRd[op_elem] && (!ElemWr[op_elem] || !phase_d);
            op_web_d = op_rd_d;
            op_din_d = ElemWrInv[op_elem] ? ~PATTERN : PATTERN;
            op_exp_d = ElemRdInv[op_elem] ? ~PATTERN : PATTERN;
        end
        chk_vld_d  = op_rd_q && !mismatch;
        chk_addr_d = addr_q;
        chk_exp_d  = op_exp_q;
    end

    // All controller state, registered outputs included.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            element_q   <= 3'd7;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            op_csb_q    <= 1'b1;
            op_web_q    <= 1'b1;
            op_din_q    <= '0;
            op_rd_q     <= 1'b0;
            op_exp_q    <= '0;
            chk_vld_q   <= 1'b0;
            chk_addr_q  <= '0;
            chk_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            element_q   <= element_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            op_csb_q    <= op_csb_d;
            op_web_q    <= op_web_d;
            op_din_q    <= op_din_d;
            op_rd_q     <= op_rd_d;
            op_exp_q    <= op_exp_d;
            chk_vld_q   <= chk_vld_d;
            chk_addr_q  <= chk_addr_d;
            chk_exp_q   <= chk_exp_d;
        end
    end

    assign bist_busy      = busy_q;
    assign bist_done      = done_q;
    assign bist_fail      = fail_q;
    assign bist_element   = element_q;
    assign bist_fail_addr = fail_addr_q;
    assign bist_fail_exp  = fail_exp_q;
    assign bist_fail_got  = fail_got_q;
    assign host_dout      = sram_dout0;
    assign host_gnt       = ~busy_q;

    sram_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .bist_sel    (busy_q),
        .host_csb    (host_csb),
        .host_web    (host_web),
        .host_wmask  (host_wmask),
        .host_addr   (host_addr),
        .host_din    (host_din),
        .bist_csb    (op_csb_q),
        .bist_web    (op_web_q),
        .bist_addr   (addr_q),
        .bist_din    (op_din_q),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0)
    );

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl with a behavioural 32x512 SRAM model.
module tb_sram_bist_ctrl;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam logic [31:0] PAT  = 32'h5555_5555;
    localparam logic [31:0] NPAT = 32'hAAAA_AAAA;

    logic          core_clk = 1'b0;
    logic          core_rstn = 1'b0;
    logic          bist_start = 1'b0;
    logic          bist_busy, bist_done, bist_fail;
    logic [2:0]    bist_element;
    logic [AW-1:0] bist_fail_addr;
    logic [DW-1:0] bist_fail_exp, bist_fail_got;
    logic          host_csb = 1'b1;
    logic          host_web = 1'b1;
    logic [3:0]    host_wmask = 4'hF;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_din = '0;
    logic [DW-1:0] host_dout;
    logic          host_gnt;
    logic          sram_csb0, sram_web0;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    int total = 0;
    int bad   = 0;

    // Model state and monitors.
    logic [DW-1:0] mem [0:511];
    logic          fault_en = 1'b0;
    int            op_cnt = 0;
    int            bist_op_cnt = 0;
    int            leak_cnt = 0;
    logic          saw_start_wr = 1'b0;

    logic [2:0]    elog [0:5199];
    logic [AW-1:0] alog [0:5199];
    logic          wlog [0:5199];
    logic [DW-1:0] dlog [0:5199];

    always #5 core_clk = ~core_clk;

    sram_bist_ctrl #(
        .AW      (AW),
        .DW      (DW),
        .PATTERN (PAT)
    ) dut (
        .core_clk       (core_clk),
        .core_rstn      (core_rstn),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_element   (bist_element),
        .bist_fail_addr (bist_fail_addr),
        .bist_fail_exp  (bist_fail_exp),
        .bist_fail_got  (bist_fail_got),
        .host_csb       (host_csb),
        .host_web       (host_web),
        .host_wmask     (host_wmask),
        .host_addr      (host_addr),
        .host_din       (host_din),
        .host_dout      (host_dout),
        .host_gnt       (host_gnt),
        .sram_csb0      (sram_csb0),
        .sram_web0      (sram_web0),
        .sram_wmask0    (sram_wmask0),
        .sram_addr0     (sram_addr0),
        .sram_din0      (sram_din0),
        .sram_dout0     (sram_dout0)
    );

    // Behavioural macro: byte-masked write, registered read, optional stuck-at-1.
    always @(posedge core_clk) begin
        if (!sram_csb0) begin
            op_cnt <= op_cnt + 1;
            if (bist_busy) bist_op_cnt <= bist_op_cnt + 1;
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
                if (sram_addr0 == 9'h020 && sram_din0 == 32'h0BAD_F00D) saw_start_wr <= 1'b1;
            end else begin
                sram_dout0 <= mem[sram_addr0] |
                              ((fault_en && sram_addr0 == 9'h1A0) ? 32'h8 : 32'h0);
            end
        end
    end

    // Host traffic must never reach the macro while BIST owns it.
    always @(negedge core_clk) begin
        if (bist_busy && !sram_csb0 && (sram_din0 == 32'hFFFF_FFFF || sram_wmask0 != 4'hF))
            leak_cnt <= leak_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic host_idle();
        host_csb = 1'b1;
        host_web = 1'b1;
        host_wmask = 4'hF;
        host_addr = '0;
        host_din = '0;
    endtask

    // Advance while busy; n = cycles spent. Optionally pokes start and host writes.
    task automatic run_busy(input int limit, input bit poke, output int n);
        n = 0;
        while (bist_busy && n < limit) begin
            if (poke) begin
                bist_start = (n == 9) || (n == 199);
                host_csb   = (n % 7 == 3) ? 1'b0 : 1'b1;
                host_web   = 1'b0;
                host_wmask = 4'h3;
                host_addr  = 9'h010;
                host_din   = 32'hFFFF_FFFF;
            end
            tick();
            n++;
            if (n + 1 < 5200) begin
                elog[n+1] = bist_element;
                alog[n+1] = sram_addr0;
                wlog[n+1] = sram_web0;
                dlog[n+1] = sram_din0;
            end
        end
        bist_start = 1'b0;
        host_idle();
    endtask

    task automatic start_run();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        elog[1] = bist_element;
        alog[1] = sram_addr0;
        wlog[1] = sram_web0;
        dlog[1] = sram_din0;
    endtask

    int n;
    int snap;
    int nbad;

    initial begin
        // Reset state.
        #12;
        chk("rst_busy", 32'(bist_busy), 32'd0);
        chk("rst_done", 32'(bist_done), 32'd0);
        chk("rst_fail", 32'(bist_fail), 32'd0);
        chk("rst_elem", 32'(bist_element), 32'd7);
        chk("rst_gnt", 32'(host_gnt), 32'd1);
        chk("rst_faddr", 32'(bist_fail_addr), 32'd0);
        chk("rst_fexp", bist_fail_exp, 32'd0);
        chk("rst_fgot", bist_fail_got, 32'd0);
        @(negedge core_clk);
        core_rstn = 1'b1;
        tick();

        // Host pass-through write/readback, then a byte-masked write.
        host_csb = 1'b0; host_web = 1'b0; host_wmask = 4'hF;
        host_addr = 9'h010; host_din = 32'hDEAD_BEEF;
        #1;
        chk("mux_addr", 32'(sram_addr0), 32'h010);
        chk("mux_din", sram_din0, 32'hDEAD_BEEF);
        tick();
        host_web = 1'b1;
        tick();
        host_idle();
        chk("host_rd", host_dout, 32'hDEAD_BEEF);
        host_csb = 1'b0; host_web = 1'b0; host_wmask = 4'h1; host_addr = 9'h010;
        host_din = 32'h0000_00AA;
        tick();
        host_web = 1'b1; host_wmask = 4'hF;
        tick();
        host_idle();
        chk("host_rd_mask", host_dout, 32'hDEAD_BEAA);
        chk("idle_elem", 32'(bist_element), 32'd7);

        // Clean run with ignored start pulses and blocked host writes.
        bist_op_cnt = 0;
        start_run();
        chk("run1_busy", 32'(bist_busy), 32'd1);
        chk("run1_gnt", 32'(host_gnt), 32'd0);
        run_busy(6000, 1'b1, n);
        chk("run1_len", 32'(n), 32'd5121);
        chk("run1_done", 32'(bist_done), 32'd1);
        chk("run1_fail", 32'(bist_fail), 32'd0);
        chk("run1_elem_end", 32'(bist_element), 32'd7);
        chk("run1_ops", 32'(bist_op_cnt), 32'd5120);
        chk("run1_leak", 32'(leak_cnt), 32'd0);
        chk("e0_start", {elog[1], 20'd0, alog[1], wlog[1]}, {3'd0, 20'd0, 9'h000, 1'b0});
        chk("e1_start", {elog[513], 20'd0, alog[513], wlog[513]}, {3'd1, 20'd0, 9'h000, 1'b1});
        chk("e2_start", 32'(elog[1537]), 32'd2);
        chk("e3_start", {elog[2561], 20'd0, alog[2561], wlog[2561]}, {3'd3, 20'd0, 9'h1FF, 1'b1});
        chk("e3_w1", dlog[2562], NPAT);
        chk("e4_start", 32'(elog[3585]), 32'd4);
        chk("e5_start", {elog[4609], 20'd0, alog[4609], wlog[4609]}, {3'd5, 20'd0, 9'h1FF, 1'b1});
        chk("e5_last", {elog[5120], 20'd0, alog[5120], wlog[5120]}, {3'd5, 20'd0, 9'h000, 1'b1});
        nbad = 0;
        for (int a = 0; a < 512; a++) if (mem[a] !== PAT) nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        // Stuck-at-1 on bit 3 of 0x1A0: caught by E1 reading E0's background.
        fault_en = 1'b1;
        start_run();
        run_busy(6000, 1'b0, n);
        chk("flt_len", 32'(n), 32'd1346);
        chk("flt_fail", 32'(bist_fail), 32'd1);
        chk("flt_done", 32'(bist_done), 32'd0);
        chk("flt_elem", 32'(bist_element), 32'd7);
        chk("flt_addr", 32'(bist_fail_addr), 32'h1A0);
        chk("flt_exp", bist_fail_exp, PAT);
        chk("flt_got", bist_fail_got, 32'h5555_555D);
        snap = op_cnt;
        repeat (20) tick();
        chk("flt_no_ops", 32'(op_cnt - snap), 32'd0);

        // Restart after fail; host write in the start cycle still lands.
        fault_en = 1'b0;
        host_csb = 1'b0; host_web = 1'b0; host_wmask = 4'hF;
        host_addr = 9'h020; host_din = 32'h0BAD_F00D;
        start_run();
        host_idle();
        chk("rs_fail_clr", 32'(bist_fail), 32'd0);
        chk("rs_busy", 32'(bist_busy), 32'd1);
        run_busy(6000, 1'b0, n);
        chk("rs_start_wr", 32'(saw_start_wr), 32'd1);
        chk("rs_len", 32'(n), 32'd5121);
        chk("rs_done", 32'(bist_done), 32'd1);
        chk("rs_fail", 32'(bist_fail), 32'd0);
        chk("rs_faddr_kept", 32'(bist_fail_addr), 32'h1A0);
        chk("rs_fgot_kept", bist_fail_got, 32'h5555_555D);

        // Reset mid-run, then a full clean pass.
        start_run();
        run_busy(2999, 1'b0, n);
        core_rstn = 1'b0;
        #2;
        chk("mr_busy", 32'(bist_busy), 32'd0);
        chk("mr_done", 32'(bist_done), 32'd0);
        chk("mr_fail", 32'(bist_fail), 32'd0);
        chk("mr_elem", 32'(bist_element), 32'd7);
        chk("mr_gnt", 32'(host_gnt), 32'd1);
        chk("mr_faddr", 32'(bist_fail_addr), 32'd0);
        @(negedge core_clk);
        core_rstn = 1'b1;
        tick();
        start_run();
        run_busy(6000, 1'b0, n);
        chk("mr_run_len", 32'(n), 32'd5121);
        chk("mr_run_done", 32'(bist_done), 32'd1);
        chk("mr_run_fail", 32'(bist_fail), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
March C- built-in self-test controller and port owner for the single 1rw port of the 32x512 management SRAM macro. When idle, the host requester (Wishbone-side SRAM glue) passes straight through to the macro. After bist_start, the controller takes the port, runs the full March C- sequence, and reports pass/fail with first-failure diagnostics. It sits between the mgmt SoC RAM interface and the SRAM macro instance.

Parameters:
AW, 9, SRAM address width; depth = 2**AW.
DW, 32, data width; wmask width = DW/8.
PATTERN, 32'h5555_5555, data background; "0" = PATTERN, "1" = ~PATTERN.

Ports:
core_clk  in  1  system clock
core_rstn  in  1  asynchronous active-low reset
bist_start  in  1  single-cycle start request
bist_busy  out  1  test running; port owned by BIST
bist_done  out  1  test finished with no mismatch (sticky until next start)
bist_fail  out  1  mismatch detected (sticky until next start)
bist_element  out  3  current March element 0-5; 7 when idle
bist_fail_addr  out  AW  address of first mismatch
bist_fail_exp  out  DW  expected word at first mismatch
bist_fail_got  out  DW  read word at first mismatch
host_csb, host_web  in  1 each  host chip select / write enable (active low)
host_wmask  in  4  host byte write mask
host_addr  in  AW  host address
host_din  in  DW  host write data
host_dout  out  DW  read data to host (= sram_dout0, always)
host_gnt  out  1  host owns the port (= ~bist_busy)
sram_csb0, sram_web0  out  1 each  macro port 0 controls (active low)
sram_wmask0  out  4  macro byte mask
sram_addr0  out  AW  macro address
sram_din0  out  DW  macro write data
sram_dout0  in  DW  macro read data, valid the cycle after the read is issued

Behaviour:
- Reset: state IDLE, busy/done/fail = 0, element = 7, fail_* = 0, address counter = 0. The port is released to the host immediately (async).
- Port mux: busy=0 -> sram_* = host_* combinationally; busy=1 -> sram_* = BIST registers and host inputs are ignored. BIST writes always use wmask = 4'hF.
- bist_start is sampled only when busy=0. On acceptance: done and fail clear, busy goes to 1 on the next edge, and the first BIST op is captured at the following edge. A host op presented in the start cycle completes normally. bist_start while busy is ignored.
- Elements (up = addr 0 -> depth-1, down = depth-1 -> 0):
  - E0 up W0
  - E1 up R0,W1
  - E2 up R1,W0
  - E3 down R0,W1
  - E4 down R1,W0
  - E5 down R0
- States: IDLE, E0..E5, DRAIN, END.
- Single-op elements (E0, E5) issue one op per cycle.
- RW elements alternate two sub-cycles per address: READ (csb=0, web=1), then WRITE (csb=0, web=0). The read data returning during the WRITE sub-cycle is compared against the expected word.
- E5 reads are compared one cycle later (pipelined). DRAIN performs the last E5 compare, then END.
- Address counter wraps at the element boundary: an up element ends at depth-1, a down element ends at 0. The next element starts at its own start address with no idle cycle.
- Total duration from first op to done/fail: 10*depth + 1 cycles (5121 for AW=9).
- Compare: a mismatch in any bit latches fail_addr, fail_exp and fail_got (first failure only), sets fail=1, clears busy on the next edge, and returns to IDLE (abort, no further ops).
- Pass: END sets done=1, busy=0, element=7.
- Reset mid-test: everything returns to reset values and the SRAM contents are undefined.

Decomposition:
- Shared package: element encoding (E0..E5, IDLE=7), state enum, March element table (direction, read-expected polarity, write polarity) as constants.
- One sub-module, sram_port_mux: pure owner-select mux for host vs BIST port signals.
- Sequencing, address counter, compare pipeline and status registers stay in sram_bist_ctrl.

Test Plan:
- Reset then idle: host writes 32'hDEADBEEF at addr 9'h010, then reads it back -> host_dout = 32'hDEADBEEF next cycle; host_gnt = 1; element = 7.
- Clean run: pulse start -> busy = 1 for exactly 5121 cycles of ops; done = 1, fail = 0; memory afterwards holds 32'h5555_5555 everywhere.
- Stuck-at-1 injected on bit 3 of addr 9'h1A0 in the behavioural SRAM model -> fail = 1 during E0 read-back in E1; fail_addr = 9'h1A0, fail_exp = 32'h5555_5555, fail_got = 32'h5555_555D; busy drops; no further SRAM ops.
- Start pulses issued at cycles 10 and 200 of a run -> ignored; the run still completes in 5121 cycles; host writes attempted during busy never reach the macro.
- Reset asserted at cycle 3000 of a run -> busy/done/fail = 0 and element = 7 immediately; a subsequent start runs a full clean pass.
- Restart after a fail (fault removed) -> fail clears at start acceptance; done = 1 at the end; fail_* registers retain their last value until the next mismatch.
